// File: rtl/cpu_pipe_pkg.sv
// Shared CPU pipeline types: the IF/ID entry layout and default field widths.
// The NOP encoding default lives here so every stage squashes to the same pattern.
package cpu_pipe_pkg;

  localparam int PC_W_DEF    = 16;
  localparam int INSTR_W_DEF = 16;

  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR_DEF = '0;

  typedef struct packed {
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_entry_buf.sv
// In-order FIFO of DEPTH (1 or 2) entries with head output, push/pop/clear and count.
// Only the occupancy count is reset; entry storage is qualified by count.
module if_id_entry_buf
  import cpu_pipe_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int W     = $bits(if_id_entry_t)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] ent_p0;

  generate
    if (DEPTH == 2) begin : g_skid
      logic [W-1:0] ent_p1;

      // Stage boundary: head (ent_p0) and skid slot (ent_p1)
      always_ff @(posedge clk) begin
        if (!clear) begin
          if (pop && count == 2'd2)
            ent_p0 <= ent_p1;
          else if (push && (count == 2'd0 || (pop && count == 2'd1)))
            ent_p0 <= din;
          if (push && ((count == 2'd1 && !pop) || (count == 2'd2 && pop)))
            ent_p1 <= din;
        end
      end
    end else begin : g_reg
      // Stage boundary: single holding register, replaced on any push
      always_ff @(posedge clk) begin
        if (!clear && push)
          ent_p0 <= din;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || clear)
      count <= 2'd0;
    else if (push && !pop)
      count <= count + 2'd1;
    else if (pop && !push)
      count <= count - 2'd1;
  end

  assign head = ent_p0;

endmodule

// File: rtl/if_id_pipe_stage.sv
// IF/ID pipeline stage: valid/ready handshake both sides, flush squashes to NOP.
// Define IF_ID_SKID_EN for a 2-entry skid buffer with registered-only in_ready.
module if_id_pipe_stage
  import cpu_pipe_pkg::*;
#(
  parameter int                 PC_W      = PC_W_DEF,
  parameter int                 INSTR_W   = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr
);

`ifdef IF_ID_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  localparam int ENTRY_W = PC_W + INSTR_W;

  logic [1:0]         count;
  logic [ENTRY_W-1:0] head;
  logic [PC_W-1:0]    head_pc;
  logic [INSTR_W-1:0] head_instr;
  logic               push;
  logic               pop;
  logic               vld_p0;

`ifdef IF_ID_SKID_EN
  // Registered-only ready: a decode stall reaches fetch one cycle later,
  // and the second slot absorbs the instruction already in flight.
  assign in_ready = (count < 2'd2);
`else
  assign in_ready = (count == 2'd0) | out_ready;
`endif

  assign vld_p0 = (count != 2'd0) & ~flush;
  assign push   = in_valid & in_ready & ~flush;
  assign pop    = vld_p0 & out_ready;

  if_id_entry_buf #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (flush),
    .din   ({in_pc, in_instr}),
    .head  (head),
    .count (count)
  );

  assign {head_pc, head_instr} = head;

  assign out_valid = vld_p0;
  assign out_pc    = vld_p0 ? head_pc    : '0;
  assign out_instr = vld_p0 ? head_instr : NOP_INSTR;

endmodule

// File: tb/tb_if_id_pipe_stage.sv
// Directed bench for if_id_pipe_stage with a queue scoreboard of expected entries.
// Works in both builds; IF_ID_SKID_EN selects the expected in_ready rule.
module tb_if_id_pipe_stage;
  import cpu_pipe_pkg::*;

`ifdef IF_ID_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  localparam logic [15:0] NOP = 16'h0000;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_pc;
  logic [15:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_pc;
  logic [15:0] out_instr;

  int checks = 0;
  int errors = 0;
  bit known  = 1'b0;

  if_id_entry_t q[$];

  if_id_pipe_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after negedge, compare against model, advance model.
  task automatic step(input bit r, input bit fl, input bit iv,
                      input logic [15:0] pc, input logic [15:0] instr, input bit ordy);
    bit          exp_v;
    bit          exp_rdy;
    logic [15:0] exp_pc;
    logic [15:0] exp_instr;
    if_id_entry_t e;
    @(negedge clk);
    rst       = r;
    flush     = fl;
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = instr;
    out_ready = ordy;
    #1;
    exp_v     = (q.size() != 0) && !fl;
    exp_rdy   = SKID ? (q.size() < 2) : ((q.size() == 0) || ordy);
    exp_pc    = 16'h0000;
    exp_instr = NOP;
    if (exp_v) begin
      exp_pc    = q[0].pc;
      exp_instr = q[0].instr;
    end
    if (known) begin
      check("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
      check("out_pc",    {16'b0, out_pc},    {16'b0, exp_pc});
      check("out_instr", {16'b0, out_instr}, {16'b0, exp_instr});
      check("in_ready",  {31'b0, in_ready},  {31'b0, exp_rdy});
    end
    if (r || fl) begin
      q.delete();
    end else begin
      if (exp_v && ordy) void'(q.pop_front());
      if (iv && exp_rdy) begin
        e.pc    = pc;
        e.instr = instr;
        q.push_back(e);
      end
    end
    if (r) known = 1'b1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;

    // reset, then reset-state observation
    step(1, 0, 0, 16'h0000, 16'h0000, 0);
    step(1, 0, 0, 16'h0000, 16'h0000, 0);
    step(0, 0, 0, 16'h0000, 16'h0000, 1);

    // stream three instructions with decode always ready
    step(0, 0, 1, 16'h0002, 16'h1111, 1);
    step(0, 0, 1, 16'h0004, 16'h2222, 1);
    step(0, 0, 1, 16'h0006, 16'h3333, 1);
    step(0, 0, 0, 16'h0000, 16'h0000, 1);
    step(0, 0, 0, 16'h0000, 16'h0000, 1);

    // stall with head pc=0x0010 while fetch keeps presenting 0x0012
    step(0, 0, 1, 16'h0010, 16'h4A4A, 0);
    for (int i = 0; i < 5; i++)
      step(0, 0, 1, 16'h0012, 16'h5B5B, 0);
    step(0, 0, 1, 16'h0014, 16'h6C6C, 1);
    step(0, 0, 0, 16'h0000, 16'h0000, 1);
    step(0, 0, 0, 16'h0000, 16'h0000, 1);
    step(0, 0, 0, 16'h0000, 16'h0000, 1);

    // fill while stalled, then flush with a presented instruction
    step(0, 0, 1, 16'h0020, 16'h7001, 0);
    step(0, 0, 1, 16'h0022, 16'h7002, 0);
    step(0, 1, 1, 16'h0024, 16'h7003, 0);
    step(0, 0, 0, 16'h0000, 16'h0000, 1);

    // count=1, simultaneous push of 0xA123 and pop
    step(0, 0, 1, 16'h0030, 16'h9000, 0);
    step(0, 0, 1, 16'h0032, 16'hA123, 1);
    step(0, 0, 0, 16'h0000, 16'h0000, 0);
    step(0, 0, 0, 16'h0000, 16'h0000, 1);

    // reset mid-stall with the buffer full
    step(0, 0, 1, 16'h0040, 16'hB001, 0);
    step(0, 0, 1, 16'h0042, 16'hB002, 0);
    step(1, 0, 1, 16'h0044, 16'hB003, 0);
    step(0, 0, 0, 16'h0000, 16'h0000, 0);

    // flush coinciding with reset
    step(0, 0, 1, 16'h0050, 16'hC001, 0);
    step(1, 1, 1, 16'h0052, 16'hC002, 1);
    step(0, 0, 0, 16'h0000, 16'h0000, 1);

    // mixed traffic
    for (int i = 0; i < 80; i++)
      step(0, ($urandom_range(0, 15) == 0), $urandom_range(0, 1),
           16'(2 * i + 16'h0100), 16'($urandom), $urandom_range(0, 1));
    step(0, 0, 0, 16'h0000, 16'h0000, 1);
    step(0, 0, 0, 16'h0000, 16'h0000, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
